// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the g/h/f logic-unit sweep checker:
// state encoding, vector count and the golden {g,h,f} reference function.
package logic_sweep_pkg;

    localparam int NUM_VEC = 16;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_DRIVE  = DRIVE,
        ST_SETTLE = SETTLE,
        ST_SAMPLE = SAMPLE,
        ST_DONE   = DONE
    } state_e;

    // vec[0]=x1 vec[1]=x2 vec[2]=x3 vec[3]=x4
    // g = x1x3 + x2x4 ; h = (x1 + ~x3)(~x2 + x4) ; f = g + h
    function automatic logic [2:0] ref_ghf(input logic [3:0] vec);
        logic g;
        logic h;
        g = (vec[0] & vec[2]) | (vec[1] & vec[3]);
        h = (vec[0] | ~vec[2]) & (~vec[1] | vec[3]);
        return {g, h, g | h};
    endfunction

endpackage

// File: rtl/logic_sweep_ref.sv
// Combinational wrapper around ref_ghf so the reference model can be
// exercised on its own.
module logic_sweep_ref
    import logic_sweep_pkg::*;
(
    input  logic [3:0] vec,
    output logic [2:0] ghf
);

    assign ghf = ref_ghf(vec);

endmodule

// File: rtl/logic_sweep_checker.sv
// Clocked, restartable sweep of all 16 input vectors through the g/h/f
// logic unit, comparing each response against the reference model.
// Optional feature macro: CAPTURE_EN adds a 16x3 capture file of the
// observed {g,h,f} per vector, readable through rd_idx/rd_data.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | present the current index on vec_out, load settle counter
// SETTLE | hold vec_out while the logic unit settles
// SAMPLE | compare dut_g/h/f with the reference, advance the index
// DONE   | sweep finished, verdict valid, waiting for start
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       vec_out,
    input  logic             dut_g,
    input  logic             dut_h,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             mismatch,
    output logic [3:0]       mismatch_vec
`ifdef CAPTURE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [2:0]       rd_data
`endif
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [3:0]       LAST_IDX    = 4'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       vec_out_q, vec_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       mismatch_vec_q, mismatch_vec_d;

    logic [2:0] exp_ghf;
    logic [2:0] obs_ghf;
    logic       start_acc;
    logic       sample_fail;

    logic_sweep_ref u_ref (
        .vec (vec_out_q),
        .ghf (exp_ghf)
    );

    assign obs_ghf     = {dut_g, dut_h, dut_f};
    assign start_acc   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    // mismatch must pulse within the SAMPLE cycle itself, so it is decoded
    // from the registered state rather than registered again.
    assign sample_fail = (state_q == ST_SAMPLE) && (obs_ghf != exp_ghf);

    // Next-state and output computation for the sweep sequencer
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        vec_out_d      = vec_out_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;
        err_cnt_d      = err_cnt_q;
        mismatch_vec_d = mismatch_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_DRIVE;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                vec_out_d = idx_q;
                cnt_d     = SETTLE_LOAD;
                state_d   = ST_SETTLE;
                if (idx_q == 4'd0) begin
                    err_cnt_d      = '0;
                    mismatch_vec_d = 4'd0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (sample_fail) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    mismatch_vec_d = vec_out_q;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= 4'd0;
            cnt_q          <= 4'd0;
            vec_out_q      <= 4'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_cnt_q      <= '0;
            mismatch_vec_q <= 4'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            vec_out_q      <= vec_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_cnt_q      <= err_cnt_d;
            mismatch_vec_q <= mismatch_vec_d;
        end
    end

    assign vec_out      = vec_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_cnt_q;
    assign mismatch     = sample_fail;
    assign mismatch_vec = mismatch_vec_q;

`ifdef CAPTURE_EN
    logic [2:0] cap_q [NUM_VEC];
    logic [2:0] cap_d [NUM_VEC];

    // Capture file update: wiped when a sweep is accepted, written in SAMPLE
    always_comb begin
        for (int i = 0; i < NUM_VEC; i++) begin
            cap_d[i] = cap_q[i];
        end
        if (start_acc) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                cap_d[i] = 3'b000;
            end
        end else if (state_q == ST_SAMPLE) begin
            cap_d[vec_out_q] = obs_ghf;
        end
    end

    // Capture file storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VEC; i++) begin
            if (rst) begin
                cap_q[i] <= 3'b000;
            end else begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

    assign rd_data = cap_q[rd_idx];
`endif

endmodule

// File: tb/tb_logic_sweep_checker.sv
`timescale 1ns/1ps
module tb_logic_sweep_checker;

    localparam int SETTLE = 2;
    localparam int ERR_W  = 5;
    localparam int PER    = SETTLE + 2;
    localparam int SWEEP  = 16 * PER;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       vec_out;
    logic             dut_g, dut_h, dut_f;
    logic             busy, done, pass, mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       mismatch_vec;
`ifdef CAPTURE_EN
    logic [3:0]       rd_idx;
    logic [2:0]       rd_data;
`endif

    logic [3:0] ref_vec;
    logic [2:0] ref_out;

    logic [2:0] mask [16];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         mm_cnt  = 0;
    logic [3:0] mm_last = 4'd0;

    always #5 clk = ~clk;

    logic_sweep_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vec_out      (vec_out),
        .dut_g        (dut_g),
        .dut_h        (dut_h),
        .dut_f        (dut_f),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .mismatch     (mismatch),
        .mismatch_vec (mismatch_vec)
`ifdef CAPTURE_EN
        ,
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
`endif
    );

    logic_sweep_ref u_ref_unit (
        .vec (ref_vec),
        .ghf (ref_out)
    );

    // Behavioural model of the logic unit using integer arithmetic
    function automatic logic [2:0] model_ghf(input int v);
        int x1, x2, x3, x4, gi, hi;
        logic g, h;
        x1 = v % 2;
        x2 = (v / 2) % 2;
        x3 = (v / 4) % 2;
        x4 = (v / 8) % 2;
        gi = x1 * x3 + x2 * x4;
        hi = (x1 + 1 - x3) * (1 - x2 + x4);
        g  = (gi > 0);
        h  = (hi > 0);
        return {g, h, g | h};
    endfunction

    // Logic unit under test: golden response with a per-vector fault mask
    assign {dut_g, dut_h, dut_f} = model_ghf(int'(vec_out)) ^ mask[vec_out];

    always @(negedge clk) begin
        if (mismatch === 1'b1) begin
            mm_cnt  = mm_cnt + 1;
            mm_last = vec_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vec_out"}, vec_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_mismatch"}, mismatch, 0);
        check({tag, "_mismatch_vec"}, mismatch_vec, 0);
`ifdef CAPTURE_EN
        for (int v = 0; v < 16; v++) begin
            rd_idx = 4'(v);
            #1;
            check({tag, "_cap_clr"}, rd_data, 0);
        end
`endif
    endtask

    // One sweep: optional extra start pulse at cycle busy_start_at,
    // optional reset at cycle rst_at (sweep abandoned there).
    task automatic run_sweep(input string tag, input int busy_start_at, input int rst_at);
        int         n;
        int         exp_err;
        logic [3:0] exp_last;
        int         part_err;
        logic [3:0] part_last;
        exp_err  = 0;
        exp_last = 4'd0;
        for (int v = 0; v < 16; v++) begin
            if (mask[v] != 3'b000) begin
                exp_err++;
                exp_last = 4'(v);
            end
        end
        mm_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 4 * SWEEP) begin
            if (n == rst_at) begin
                part_err  = 0;
                part_last = 4'd0;
                for (int v = 0; v < 16; v++) begin
                    if (PER * (v + 1) <= n && mask[v] != 3'b000) begin
                        part_err++;
                        part_last = 4'(v);
                    end
                end
                check({tag, "_pre_rst_err"}, err_cnt, part_err);
                check({tag, "_pre_rst_mvec"}, mismatch_vec, part_last);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_zero_outputs({tag, "_rst"});
                return;
            end
            if (n == busy_start_at) begin
                check({tag, "_busy_mid"}, busy, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_cycles"}, n, SWEEP);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_vec_out"}, vec_out, 15);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
        check({tag, "_mismatch_vec"}, mismatch_vec, exp_last);
        check({tag, "_mm_pulses"}, mm_cnt, exp_err);
        if (exp_err > 0) begin
            check({tag, "_mm_last"}, mm_last, exp_last);
        end
`ifdef CAPTURE_EN
        for (int v = 0; v < 16; v++) begin
            rd_idx = 4'(v);
            #1;
            check({tag, "_cap"}, rd_data, model_ghf(v) ^ mask[v]);
        end
`endif
    endtask

    initial begin
        logic [3:0] spot_v [5];
        logic [2:0] spot_e [5];
        spot_v = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd15};
        spot_e = '{3'b011, 3'b000, 3'b111, 3'b000, 3'b111};

        rst     = 1'b1;
        start   = 1'b0;
        ref_vec = 4'd0;
`ifdef CAPTURE_EN
        rd_idx  = 4'd0;
`endif
        for (int v = 0; v < 16; v++) mask[v] = 3'b000;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        for (int v = 0; v < 16; v++) begin
            ref_vec = 4'(v);
            #1;
            check("ref_model", ref_out, model_ghf(v));
        end
        for (int i = 0; i < 5; i++) begin
            ref_vec = spot_v[i];
            #1;
            check("ref_spot", ref_out, spot_e[i]);
        end

        run_sweep("golden", -1, -1);

        for (int v = 0; v < 16; v++) mask[v] = model_ghf(v) & 3'b010;
        run_sweep("h_stuck0", -1, -1);

        for (int v = 0; v < 16; v++) mask[v] = 3'b000;
        run_sweep("restart_clear", -1, -1);
        run_sweep("start_busy", 3 * PER + 1, -1);

        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 16; v++) begin
                mask[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            run_sweep("random", -1, -1);
        end

        for (int v = 0; v < 16; v++) begin
            mask[v] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        end
        mask[2] = 3'b001;
        run_sweep("mid_rst", -1, 7 * PER + 1);
        for (int v = 0; v < 16; v++) mask[v] = 3'b000;
        run_sweep("after_rst", -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
